// File: rtl/set_job_sched_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// set_job_sched_if : requester/engine/result bundle for set_job_sched (rev 1.0)
// -----------------------------------------------------------------------------
interface set_job_sched_if #(
  parameter int CNT_W = 16
);
  logic             req_a;
  logic [23:0]      central_a;
  logic [11:0]      radius_a;
  logic [1:0]       mode_a;
  logic             gnt_a;
  logic             req_b;
  logic [23:0]      central_b;
  logic [11:0]      radius_b;
  logic [1:0]       mode_b;
  logic             gnt_b;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_valid;
  logic [7:0]       set_candidate;
  logic             res_valid;
  logic             res_id;
  logic [7:0]       res_candidate;
  logic             res_err;
  logic             busy;
  logic [CNT_W-1:0] jobs_done;

  modport slave (
    input  req_a, central_a, radius_a, mode_a,
    input  req_b, central_b, radius_b, mode_b,
    input  set_valid, set_candidate,
    output gnt_a, gnt_b, set_en, set_central, set_radius, set_mode,
    output res_valid, res_id, res_candidate, res_err, busy, jobs_done
  );

  modport master (
    output req_a, central_a, radius_a, mode_a,
    output req_b, central_b, radius_b, mode_b,
    output set_valid, set_candidate,
    input  gnt_a, gnt_b, set_en, set_central, set_radius, set_mode,
    input  res_valid, res_id, res_candidate, res_err, busy, jobs_done
  );
endinterface
`default_nettype wire

// File: rtl/set_job_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// set_job_sched : round-robin job scheduler for one shared set engine (rev 1.0)
// -----------------------------------------------------------------------------
module set_job_sched #(
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  set_job_sched_if.slave bus
);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [23:0]      central_q, central_d;
  logic [11:0]      radius_q, radius_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cand_q, cand_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic             pick_b;
  logic             gnt_a, gnt_b;

  // B wins when alone, or when both request and A was served last
  assign pick_b = bus.req_b & (~bus.req_a | ~last_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    id_d      = id_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
    err_d     = err_q;
    jobs_d    = jobs_q;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_a | bus.req_b) begin
          gnt_a     = ~pick_b;
          gnt_b     = pick_b;
          id_d      = pick_b;
          last_d    = pick_b;
          central_d = pick_b ? bus.central_b : bus.central_a;
          radius_d  = pick_b ? bus.radius_b  : bus.radius_a;
          mode_d    = pick_b ? bus.mode_b    : bus.mode_a;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the final watchdog cycle still counts
        if (bus.set_valid) begin
          cand_d  = bus.set_candidate;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == C_TMO_LAST) begin
          cand_d  = 8'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!err_q) begin
          jobs_d = jobs_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      cand_q    <= '0;
      err_q     <= 1'b0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      id_q      <= id_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      err_q     <= err_d;
      jobs_q    <= jobs_d;
    end
  end

  // Grants depend on live requests, so they are masked while reset is held
  assign bus.gnt_a         = gnt_a & rst_n;
  assign bus.gnt_b         = gnt_b & rst_n;
  assign bus.set_en        = (state_q == S_LAUNCH);
  assign bus.set_central   = central_q;
  assign bus.set_radius    = radius_q;
  assign bus.set_mode      = mode_q;
  assign bus.res_valid     = (state_q == S_RESP);
  assign bus.res_id        = id_q;
  assign bus.res_candidate = cand_q;
  assign bus.res_err       = err_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.jobs_done     = jobs_q;
endmodule
`default_nettype wire

// File: tb/tb_set_job_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_set_job_sched : randomized self-checking bench with transaction model (rev 1.0)
// -----------------------------------------------------------------------------
module tb_set_job_sched;
  localparam int TIMEOUT = 80;
  localparam int CNT_W   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_job_sched_if #(.CNT_W(CNT_W)) bus ();

  set_job_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit m_last;   // last requester served: 0 = A, 1 = B
  int m_jobs;   // successful jobs since reset (unwrapped)

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.gnt_a, bus.gnt_b, bus.set_en, bus.set_central, bus.set_radius,
                bus.set_mode, bus.res_valid, bus.res_id, bus.res_candidate,
                bus.res_err, bus.busy, bus.jobs_done});
  endfunction

  function automatic logic [63:0] jobs_exp();
    return 64'(m_jobs % (1 << CNT_W));
  endfunction

  task automatic do_reset(input bit ra, input bit rb);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_a     = ra;
    bus.req_b     = rb;
    bus.set_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    m_jobs = 0;
  endtask

  // One complete job: request, grant, launch, engine reply after dly cycles
  // (dly > TIMEOUT means the engine is too late), result, statistics.
  task automatic do_job(input bit ra, input bit rb, input bit hold, input int dly,
                        input logic [7:0] cand,
                        input logic [23:0] ca, input logic [11:0] rda, input logic [1:0] ma,
                        input logic [23:0] cb, input logic [11:0] rdb, input logic [1:0] mb);
    bit          exp_b;
    bit          exp_err;
    bit          seen;
    int          resp_t;
    logic [37:0] exp_ops;
    exp_b         = rb && (!ra || !m_last);
    exp_err       = (dly > TIMEOUT);
    resp_t        = (exp_err ? TIMEOUT : dly) + 1;
    exp_ops       = exp_b ? {cb, rdb, mb} : {ca, rda, ma};
    bus.req_a     = ra;
    bus.req_b     = rb;
    bus.central_a = ca;
    bus.radius_a  = rda;
    bus.mode_a    = ma;
    bus.central_b = cb;
    bus.radius_b  = rdb;
    bus.mode_b    = mb;
    #1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.gnt_a | bus.gnt_b) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("gnt_seen", 64'(seen), 64'd1);
    check("gnt_who", {bus.gnt_a, bus.gnt_b}, exp_b ? 64'b01 : 64'b10);
    m_last = exp_b;

    @(negedge clk);
    if (!hold) begin
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
    end
    bus.central_a = 24'($urandom);
    bus.radius_a  = 12'($urandom);
    bus.mode_a    = 2'($urandom);
    bus.central_b = 24'($urandom);
    bus.radius_b  = 12'($urandom);
    bus.mode_b    = 2'($urandom);
    #1;
    check("launch", {bus.set_en, bus.busy, bus.gnt_a, bus.gnt_b}, 64'b1100);
    check("launch_ops", {bus.set_central, bus.set_radius, bus.set_mode}, 64'(exp_ops));

    for (int t = 1; t <= resp_t; t++) begin
      @(negedge clk);
      bus.set_valid     = (t == dly);
      bus.set_candidate = (t == dly) ? cand : 8'($urandom);
      #1;
      if (t < resp_t) begin
        check("wait_quiet", {bus.res_valid, bus.set_en, bus.gnt_a, bus.gnt_b, bus.busy},
              64'b00001);
      end else begin
        check("res_valid", 64'(bus.res_valid), 64'd1);
        check("res_id", 64'(bus.res_id), 64'(exp_b));
        check("res_cand", 64'(bus.res_candidate), exp_err ? 64'd0 : 64'(cand));
        check("res_err", 64'(bus.res_err), 64'(exp_err));
        check("ops_stable", {bus.set_central, bus.set_radius, bus.set_mode}, 64'(exp_ops));
      end
    end
    if (!exp_err) m_jobs++;

    @(negedge clk);
    bus.set_valid = 1'b0;
    #1;
    check("post_idle", {bus.res_valid, bus.busy, bus.set_en}, 64'd0);
    check("jobs_done", 64'(bus.jobs_done), jobs_exp());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bit ra, rb;
    int dly, r;
    bus.req_a = 1'b0;  bus.central_a = '0;  bus.radius_a = '0;  bus.mode_a = '0;
    bus.req_b = 1'b0;  bus.central_b = '0;  bus.radius_b = '0;  bus.mode_b = '0;
    bus.set_valid = 1'b0;
    bus.set_candidate = '0;

    do_reset(1'b0, 1'b0);

    do_job(1, 0, 0, 64, 8'd29, 24'h44_0000, 12'h300, 2'd0, 24'h0, 12'h0, 2'd0);
    // engine silent: watchdog abort; its late strobe lands in RESP and is ignored
    do_job(1, 0, 0, TIMEOUT + 1, 8'd55, 24'($urandom), 12'($urandom), 2'($urandom),
           24'($urandom), 12'($urandom), 2'($urandom));
    // reply on the last watchdog cycle must still be accepted
    do_job(0, 1, 0, TIMEOUT, 8'd7, 24'($urandom), 12'($urandom), 2'($urandom),
           24'($urandom), 12'($urandom), 2'($urandom));

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.set_valid     = 1'b1;
      bus.set_candidate = 8'($urandom);
      #1;
      check("idle_spurious", {bus.res_valid, bus.busy}, 64'd0);
    end
    @(negedge clk);
    bus.set_valid = 1'b0;
    #1;
    check("idle_spur_jobs", 64'(bus.jobs_done), jobs_exp());

    // reset in the middle of WAIT, then a stale engine strobe
    bus.req_a     = 1'b1;
    bus.central_a = 24'($urandom);
    #1;
    check("rst_job_gnt", 64'(bus.gnt_a), 64'd1);
    @(negedge clk);
    bus.req_a = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wait_outs", all_outs(), 64'd0);
    rst_n             = 1'b1;
    bus.set_valid     = 1'b1;
    bus.set_candidate = 8'd99;
    m_last            = 1'b1;
    m_jobs            = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.set_valid = 1'b0;
      #1;
      check("rst_stale_quiet", {bus.res_valid, bus.busy, bus.set_en}, 64'd0);
    end
    do_job(1, 0, 0, 40, 8'd123, 24'($urandom), 12'($urandom), 2'($urandom),
           24'($urandom), 12'($urandom), 2'($urandom));

    // both requesters held from reset: strict alternation A, B, A, B
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_job(1, 1, (i < 3), 30, (i % 2 == 0) ? 8'd10 : 8'd20,
             24'($urandom), 12'($urandom), 2'($urandom),
             24'($urandom), 12'($urandom), 2'($urandom));
    end

    for (int i = 0; i < 24; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      r  = int'($urandom_range(0, 9));
      if (r == 0)      dly = TIMEOUT + 1;
      else if (r == 1) dly = TIMEOUT;
      else             dly = int'($urandom_range(1, 60));
      do_job(ra, rb, 0, dly, 8'($urandom),
             24'($urandom), 12'($urandom), 2'($urandom),
             24'($urandom), 12'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/set_job_sched.md
Name: set_job_sched

Overview:
- Job scheduler in front of one shared set-counting engine (8x8 lattice, up to three circles, 2-bit mode, 8-bit candidate count).
- Two requesters (A, B) submit jobs of central/radius/mode. The block arbitrates round-robin and launches one job at a time on the engine.
- It holds the engine operands stable, waits for the engine's result pulse with a watchdog, and returns candidate plus requester ID.
- It keeps a completed-job statistic counter.

Parameters:
- TIMEOUT, 80, cycles in WAIT before the job is aborted (engine nominally answers in about 65 cycles).
- CNT_W, 16, width of the completed-jobs counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_a  in  1  requester A job request; held high until gnt_a.
- central_a  in  24  A circle centres {x1,y1,x2,y2,x3,y3}, 4 bits each.
- radius_a  in  12  A radii {r1,r2,r3}.
- mode_a  in  2  A mode.
- gnt_a  out  1  one-cycle grant; A operands sampled this cycle.
- req_b, central_b, radius_b, mode_b, gnt_b  same as A, for requester B.
- set_en  out  1  one-cycle engine start pulse.
- set_central  out  24  operand to engine, stable from launch to result.
- set_radius  out  12  operand to engine.
- set_mode  out  2  operand to engine.
- set_valid  in  1  engine result strobe.
- set_candidate  in  8  engine count, qualified by set_valid.
- res_valid  out  1  one-cycle result strobe to requesters.
- res_id  out  1  0 = A, 1 = B; qualified by res_valid.
- res_candidate  out  8  latched count; 0 on error.
- res_err  out  1  1 = job timed out; qualified by res_valid.
- busy  out  1  high in every state except IDLE.
- jobs_done  out  CNT_W  count of res_valid pulses with res_err = 0.

Behaviour:
- Reset (rst_n = 0 at clk edge): state IDLE.
  - All outputs 0: gnt_*, set_en, set_* operands, res_*, busy, jobs_done.
  - Timer 0; round-robin pointer last = B, so A has priority first.
  - Reset mid-job aborts the job with no res_valid; a later engine set_valid is ignored.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - One request: grant it.
  - Both requesting: grant the one not equal to last.
  - On grant: pulse gnt_x for 1 cycle, latch its central/radius/mode into set_* registers, record id, update last, go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH: set_en = 1 for exactly this cycle, timer cleared, go to WAIT.
- WAIT: timer increments every cycle.
  - On set_valid: latch set_candidate, err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: candidate = 0, err = 1, go to RESP.
  - set_valid in the same cycle as the timeout condition: valid wins, err = 0.
- RESP: res_valid = 1 for one cycle with res_id/res_candidate/res_err; jobs_done += 1 if err = 0; go to IDLE.
- Arbitration happens only in IDLE. Minimum spacing between grants is 4 cycles plus engine latency.
- Latencies:
  - gnt_x to set_en: 1 cycle.
  - set_valid to res_valid: 1 cycle.
  - res_valid to next gnt: 1 cycle (IDLE cycle).
- set_* operands keep their value after a job until the next grant; set_en stays 0 outside LAUNCH.
- set_valid seen in IDLE, LAUNCH or RESP is ignored.
- jobs_done wraps modulo 2^CNT_W.
- Requests dropped before grant are not remembered. Operand changes after gnt do not affect the running job.

Test Plan:
- Reset, then req_a with central = 24'h44_0000, radius = 12'h300, mode = 0, engine stub answers 29 after 64 cycles.
  - Expect gnt_a one cycle, set_en one cycle later with operands = A's.
  - Expect res_valid with res_id = 0, res_candidate = 29, res_err = 0; jobs_done = 1.
- req_a and req_b both held high from reset, stub answers 10 then 20.
  - Expect grant order A, B, A, B.
  - Expect res_id 0/1 alternating with candidates 10, 20; no double grant.
- Stub never asserts set_valid.
  - Expect res_valid exactly TIMEOUT+1 cycles after set_en with res_err = 1, res_candidate = 0.
  - Expect jobs_done unchanged and busy low the following cycle.
- set_valid asserted in the same cycle as the timeout condition with candidate 7.
  - Expect res_err = 0, res_candidate = 7.
- rst_n low during WAIT, stub then asserts set_valid.
  - Expect all outputs 0, no res_valid, and the next req_a granted normally.
- Spurious set_valid while in IDLE.
  - Expect no res_valid and jobs_done unchanged.
